// File: rtl/pc_redirect_unit_pkg.sv
// Shared definitions for the fetch-PC redirect unit.
// Contents:
//   RESET_PC_DEFAULT - PC value loaded on reset unless the top overrides it
//   state_e          - RUN (normal fetch) / HOLD (a redirect or annul is waiting for fetch)
//   tgt_sel_e        - which next-PC source the ID-stage decision selects
//   br_offset()      - sign-extended, word-scaled branch displacement
package pc_redirect_unit_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_e;

    typedef enum logic [2:0] {
        SEL_SEQ       = 3'd0,
        SEL_BR        = 3'd1,
        SEL_J         = 3'd2,
        SEL_JR        = 3'd3,
        SEL_LIKELY_NT = 3'd4
    } tgt_sel_e;

    function automatic logic signed [31:0] br_offset(input logic [15:0] imm);
        logic signed [31:0] off;
        off = signed'({{14{imm[15]}}, imm, 2'b00});
        return off;
    endfunction

endpackage

// File: rtl/pc_redirect_unit_if.sv
// Bundle between the ID-stage comparator/fetch logic and the PC redirect unit.
// Ports:
//   stall_f, stall_d                       - fetch / decode stall qualifiers
//   br_en, br_taken, br_likely, j_en, jr_en - resolved control-flow decision
//   pc_d, imm16, idx26, rs_val             - operands for target generation
//   pc_f, redirect, flush_d, pending, misalign_err - unit outputs
// master drives the decision and reads the PC; slave is the redirect unit.
interface pc_redirect_unit_if;
    logic        stall_f;
    logic        stall_d;
    logic        br_en;
    logic        br_taken;
    logic        br_likely;
    logic        j_en;
    logic        jr_en;
    logic [31:0] pc_d;
    logic [15:0] imm16;
    logic [25:0] idx26;
    logic [31:0] rs_val;
    logic [31:0] pc_f;
    logic        redirect;
    logic        flush_d;
    logic        pending;
    logic        misalign_err;

    modport master (
        output stall_f, stall_d, br_en, br_taken, br_likely, j_en, jr_en,
        output pc_d, imm16, idx26, rs_val,
        input  pc_f, redirect, flush_d, pending, misalign_err
    );

    modport slave (
        input  stall_f, stall_d, br_en, br_taken, br_likely, j_en, jr_en,
        input  pc_d, imm16, idx26, rs_val,
        output pc_f, redirect, flush_d, pending, misalign_err
    );
endinterface

// File: rtl/pc_redirect_unit_npc_target_calc.sv
// Combinational next-PC source selection and target generation.
// Ports:
//   in  pc_d, pc_f, imm16, idx26, rs_val - operands
//   in  stall_d, br_en, br_taken, br_likely, j_en, jr_en - decision
//   out sel      - selected source (jr > j > branch priority)
//   out target   - target of a taken decision, or pc_d+8 for likely-not-taken
//   out seq_pc   - pc_f + 4 (wraps mod 2^32)
//   out take, annul, misalign - decision summary for the PC owner
module npc_target_calc
    import pc_redirect_unit_pkg::*;
(
    input  logic [31:0] pc_d,
    input  logic [31:0] pc_f,
    input  logic [15:0] imm16,
    input  logic [25:0] idx26,
    input  logic [31:0] rs_val,
    input  logic        stall_d,
    input  logic        br_en,
    input  logic        br_taken,
    input  logic        br_likely,
    input  logic        j_en,
    input  logic        jr_en,
    output tgt_sel_e    sel,
    output logic [31:0] target,
    output logic [31:0] seq_pc,
    output logic        take,
    output logic        annul,
    output logic        misalign
);
    logic        dv;
    logic [31:0] pc_d_p4;

    always_comb begin
        dv      = !stall_d && (br_en || j_en || jr_en);
        pc_d_p4 = pc_d + 32'd4;
        seq_pc  = pc_f + 32'd4;

        sel = SEL_SEQ;
        if (dv) begin
            if (jr_en)                     sel = SEL_JR;
            else if (j_en)                 sel = SEL_J;
            else if (br_en && br_taken)    sel = SEL_BR;
            else if (br_en && br_likely)   sel = SEL_LIKELY_NT;
        end

        case (sel)
            SEL_BR:        target = 32'($signed(pc_d_p4) + br_offset(imm16));
            SEL_J:         target = {pc_d_p4[31:28], idx26, 2'b00};
            SEL_JR:        target = rs_val;
            // Skip the annulled delay slot: resume after it.
            SEL_LIKELY_NT: target = pc_d + 32'd8;
            default:       target = seq_pc;
        endcase

        take     = (sel == SEL_BR) || (sel == SEL_J) || (sel == SEL_JR);
        annul    = (sel == SEL_LIKELY_NT);
        misalign = dv && jr_en && (rs_val[1:0] != 2'b00);
    end
endmodule

// File: rtl/pc_redirect_unit.sv
// Fetch-PC owner driven by the ID-stage branch decision.
// Loads branch/jump/jr targets, annuls the delay slot of an untaken
// branch-likely, and parks a redirect that resolves during a fetch stall
// until fetch can accept it.
// Ports:
//   clk, reset - clock, synchronous active-high reset
//   bus        - pc_redirect_unit_if.slave (decision in, pc_f/pulses out)
// redirect, flush_d and misalign_err describe the upcoming clock edge.
module pc_redirect_unit
    import pc_redirect_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    pc_redirect_unit_if.slave    bus
);
    state_e      state_q, state_nxt;
    logic [31:0] pc_q, pc_nxt;
    logic [31:0] pend_tgt_q, pend_tgt_nxt;
    logic        pend_flush_q, pend_flush_nxt;
    logic        redirect_c, flush_c;

    tgt_sel_e    sel;
    logic [31:0] target;
    logic [31:0] seq_pc;
    logic        take, annul, misalign;

    npc_target_calc u_calc (
        .pc_d      (bus.pc_d),
        .pc_f      (pc_q),
        .imm16     (bus.imm16),
        .idx26     (bus.idx26),
        .rs_val    (bus.rs_val),
        .stall_d   (bus.stall_d),
        .br_en     (bus.br_en),
        .br_taken  (bus.br_taken),
        .br_likely (bus.br_likely),
        .j_en      (bus.j_en),
        .jr_en     (bus.jr_en),
        .sel       (sel),
        .target    (target),
        .seq_pc    (seq_pc),
        .take      (take),
        .annul     (annul),
        .misalign  (misalign)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= RUN;
            pc_q         <= RESET_PC;
            pend_tgt_q   <= 32'd0;
            pend_flush_q <= 1'b0;
        end else begin
            state_q      <= state_nxt;
            pc_q         <= pc_nxt;
            pend_tgt_q   <= pend_tgt_nxt;
            pend_flush_q <= pend_flush_nxt;
        end
    end

    always_comb begin
        state_nxt      = state_q;
        pc_nxt         = pc_q;
        pend_tgt_nxt   = pend_tgt_q;
        pend_flush_nxt = pend_flush_q;
        redirect_c     = 1'b0;
        flush_c        = 1'b0;

        case (state_q)
            RUN: begin
                if (take) begin
                    if (!bus.stall_f) begin
                        pc_nxt     = target;
                        redirect_c = 1'b1;
                    end else begin
                        pend_tgt_nxt   = target;
                        pend_flush_nxt = 1'b0;
                        state_nxt      = HOLD;
                    end
                end else if (annul) begin
                    // Unstalled: the delay slot is already fetched, so stepping
                    // sequentially lands on pc_d+8 while IF/ID is cleared.
                    if (!bus.stall_f) begin
                        pc_nxt  = seq_pc;
                        flush_c = 1'b1;
                    end else begin
                        pend_tgt_nxt   = target;
                        pend_flush_nxt = 1'b1;
                        state_nxt      = HOLD;
                    end
                end else if (!bus.stall_f) begin
                    pc_nxt = seq_pc;
                end
            end
            HOLD: begin
                // Decision inputs are ignored: this is the delay-slot window.
                if (!bus.stall_f) begin
                    pc_nxt         = pend_tgt_q;
                    redirect_c     = !pend_flush_q;
                    flush_c        = pend_flush_q;
                    pend_flush_nxt = 1'b0;
                    state_nxt      = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase

        if (reset) begin
            redirect_c = 1'b0;
            flush_c    = 1'b0;
        end
    end

    assign bus.pc_f         = pc_q;
    assign bus.redirect     = redirect_c;
    assign bus.flush_d      = flush_c;
    assign bus.pending      = (state_q == HOLD) && !reset;
    assign bus.misalign_err = misalign && !reset;

    logic unused_sel;
    assign unused_sel = ^sel;
endmodule

// File: tb/tb_pc_redirect_unit.sv
module tb_pc_redirect_unit;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pc_redirect_unit_if bus();

    pc_redirect_unit #(.RESET_PC(32'h0000_3000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_pc;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.stall_f   = 1'b0;
        bus.stall_d   = 1'b0;
        bus.br_en     = 1'b0;
        bus.br_taken  = 1'b0;
        bus.br_likely = 1'b0;
        bus.j_en      = 1'b0;
        bus.jr_en     = 1'b0;
        bus.pc_d      = 32'd0;
        bus.imm16     = 16'd0;
        bus.idx26     = 26'd0;
        bus.rs_val    = 32'd0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        bus.jr_en  = 1'b1;
        bus.rs_val = 32'h0000_0003;
        tick();
        tick();
        checks++;
        if (bus.pc_f !== 32'h0000_3000) begin
            errors++; $display("FAIL reset_pc: got %h want %h", bus.pc_f, 32'h0000_3000);
        end
        checks++;
        if ({bus.redirect, bus.flush_d, bus.pending, bus.misalign_err} !== 4'b0000) begin
            errors++; $display("FAIL reset_pulses: got %b want 0000",
                               {bus.redirect, bus.flush_d, bus.pending, bus.misalign_err});
        end
        reset = 1'b0;
        idle_inputs();
    endtask

    task automatic test_sequential();
        for (int i = 1; i <= 3; i++) begin
            #1;
            checks++;
            if ({bus.redirect, bus.flush_d, bus.pending, bus.misalign_err} !== 4'b0000) begin
                errors++; $display("FAIL seq_pulses: got %b want 0000",
                                   {bus.redirect, bus.flush_d, bus.pending, bus.misalign_err});
            end
            exp_q.push_back(32'h0000_3000 + 32'(4 * i));
            tick();
            exp_pc = exp_q.pop_front();
            checks++;
            if (bus.pc_f !== exp_pc) begin
                errors++; $display("FAIL seq_pc: got %h want %h", bus.pc_f, exp_pc);
            end
        end
    endtask

    task automatic test_branch();
        bus.pc_d     = 32'h0000_3008;
        bus.br_en    = 1'b1;
        bus.br_taken = 1'b1;
        bus.imm16    = 16'hFFFE;
        #1;
        checks++;
        if (bus.redirect !== 1'b1 || bus.flush_d !== 1'b0) begin
            errors++; $display("FAIL br_redirect: got r=%b f=%b want r=1 f=0", bus.redirect, bus.flush_d);
        end
        exp_q.push_back(32'h0000_3004);
        tick();
        idle_inputs();
        exp_pc = exp_q.pop_front();
        checks++;
        if (bus.pc_f !== exp_pc) begin
            errors++; $display("FAIL br_pc: got %h want %h", bus.pc_f, exp_pc);
        end
    endtask

    task automatic test_stalled_jump();
        logic [31:0] held;
        held = bus.pc_f;
        for (int i = 0; i < 3; i++) begin
            idle_inputs();
            bus.stall_f = 1'b1;
            if (i == 0) begin
                bus.j_en  = 1'b1;
                bus.pc_d  = 32'h0000_3010;
                bus.idx26 = 26'h0000C40;
            end
            #1;
            checks++;
            if (bus.redirect !== 1'b0 || bus.pending !== (i > 0)) begin
                errors++; $display("FAIL jstall_pulse[%0d]: got r=%b p=%b want r=0 p=%b",
                                   i, bus.redirect, bus.pending, (i > 0));
            end
            exp_q.push_back(held);
            tick();
            exp_pc = exp_q.pop_front();
            checks++;
            if (bus.pc_f !== exp_pc || bus.pending !== 1'b1) begin
                errors++; $display("FAIL jstall_hold[%0d]: got pc=%h p=%b want pc=%h p=1",
                                   i, bus.pc_f, bus.pending, exp_pc);
            end
        end
        idle_inputs();
        #1;
        checks++;
        if (bus.redirect !== 1'b1 || bus.flush_d !== 1'b0) begin
            errors++; $display("FAIL jstall_release: got r=%b f=%b want r=1 f=0", bus.redirect, bus.flush_d);
        end
        exp_q.push_back(32'h0000_3100);
        tick();
        exp_pc = exp_q.pop_front();
        checks++;
        if (bus.pc_f !== exp_pc || bus.pending !== 1'b0) begin
            errors++; $display("FAIL jstall_pc: got pc=%h p=%b want pc=%h p=0", bus.pc_f, bus.pending, exp_pc);
        end
    endtask

    task automatic jump_to_3024();
        idle_inputs();
        bus.j_en  = 1'b1;
        bus.pc_d  = 32'h0000_3000;
        bus.idx26 = 26'h0000C09;
        exp_q.push_back(32'h0000_3024);
        tick();
        idle_inputs();
        exp_pc = exp_q.pop_front();
        checks++;
        if (bus.pc_f !== exp_pc) begin
            errors++; $display("FAIL j_setup: got %h want %h", bus.pc_f, exp_pc);
        end
    endtask

    task automatic test_likely_nt();
        jump_to_3024();
        bus.br_en     = 1'b1;
        bus.br_likely = 1'b1;
        bus.pc_d      = 32'h0000_3020;
        #1;
        checks++;
        if (bus.flush_d !== 1'b1 || bus.redirect !== 1'b0) begin
            errors++; $display("FAIL lnt_flush: got f=%b r=%b want f=1 r=0", bus.flush_d, bus.redirect);
        end
        exp_q.push_back(32'h0000_3028);
        tick();
        idle_inputs();
        exp_pc = exp_q.pop_front();
        checks++;
        if (bus.pc_f !== exp_pc) begin
            errors++; $display("FAIL lnt_pc: got %h want %h", bus.pc_f, exp_pc);
        end

        jump_to_3024();
        for (int i = 0; i < 2; i++) begin
            idle_inputs();
            bus.stall_f = 1'b1;
            if (i == 0) begin
                bus.br_en     = 1'b1;
                bus.br_likely = 1'b1;
                bus.pc_d      = 32'h0000_3020;
            end
            #1;
            checks++;
            if (bus.flush_d !== 1'b0 || bus.redirect !== 1'b0) begin
                errors++; $display("FAIL lnt_stall[%0d]: got f=%b r=%b want f=0 r=0", i, bus.flush_d, bus.redirect);
            end
            exp_q.push_back(32'h0000_3024);
            tick();
            exp_pc = exp_q.pop_front();
            checks++;
            if (bus.pc_f !== exp_pc || bus.pending !== 1'b1) begin
                errors++; $display("FAIL lnt_hold[%0d]: got pc=%h p=%b want pc=%h p=1",
                                   i, bus.pc_f, bus.pending, exp_pc);
            end
        end
        idle_inputs();
        #1;
        checks++;
        if (bus.flush_d !== 1'b1 || bus.redirect !== 1'b0) begin
            errors++; $display("FAIL lnt_release: got f=%b r=%b want f=1 r=0", bus.flush_d, bus.redirect);
        end
        exp_q.push_back(32'h0000_3028);
        tick();
        exp_pc = exp_q.pop_front();
        checks++;
        if (bus.pc_f !== exp_pc || bus.pending !== 1'b0) begin
            errors++; $display("FAIL lnt_stall_pc: got pc=%h p=%b want pc=%h p=0", bus.pc_f, bus.pending, exp_pc);
        end
    endtask

    task automatic test_jr_misalign();
        idle_inputs();
        bus.jr_en    = 1'b1;
        bus.j_en     = 1'b1;
        bus.br_en    = 1'b1;
        bus.br_taken = 1'b1;
        bus.pc_d     = 32'h0000_5000;
        bus.idx26    = 26'h0000100;
        bus.imm16    = 16'h0010;
        bus.rs_val   = 32'h0000_3002;
        #1;
        checks++;
        if (bus.misalign_err !== 1'b1 || bus.redirect !== 1'b1) begin
            errors++; $display("FAIL jr_misalign: got m=%b r=%b want m=1 r=1", bus.misalign_err, bus.redirect);
        end
        exp_q.push_back(32'h0000_3002);
        tick();
        idle_inputs();
        exp_pc = exp_q.pop_front();
        checks++;
        if (bus.pc_f !== exp_pc) begin
            errors++; $display("FAIL jr_pc: got %h want %h", bus.pc_f, exp_pc);
        end
    endtask

    task automatic test_priority_j_over_br();
        idle_inputs();
        bus.j_en     = 1'b1;
        bus.br_en    = 1'b1;
        bus.br_taken = 1'b1;
        bus.pc_d     = 32'h1000_0000;
        bus.idx26    = 26'h0000200;
        bus.imm16    = 16'h0100;
        #1;
        checks++;
        if (bus.misalign_err !== 1'b0 || bus.redirect !== 1'b1) begin
            errors++; $display("FAIL prio_pulse: got m=%b r=%b want m=0 r=1", bus.misalign_err, bus.redirect);
        end
        exp_q.push_back(32'h1000_0800);
        tick();
        idle_inputs();
        exp_pc = exp_q.pop_front();
        checks++;
        if (bus.pc_f !== exp_pc) begin
            errors++; $display("FAIL prio_pc: got %h want %h", bus.pc_f, exp_pc);
        end
    endtask

    task automatic test_reset_in_hold();
        idle_inputs();
        bus.jr_en   = 1'b1;
        bus.rs_val  = 32'h0000_4000;
        bus.stall_f = 1'b1;
        tick();
        idle_inputs();
        bus.stall_f = 1'b1;
        #1;
        checks++;
        if (bus.pending !== 1'b1) begin
            errors++; $display("FAIL rhold_pending: got %b want 1", bus.pending);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (bus.pc_f !== 32'h0000_3000 || bus.pending !== 1'b0) begin
            errors++; $display("FAIL rhold_reset: got pc=%h p=%b want pc=00003000 p=0", bus.pc_f, bus.pending);
        end
        bus.stall_f = 1'b0;
        #1;
        checks++;
        if (bus.redirect !== 1'b0) begin
            errors++; $display("FAIL rhold_redirect: got %b want 0", bus.redirect);
        end
        exp_q.push_back(32'h0000_3004);
        tick();
        exp_pc = exp_q.pop_front();
        checks++;
        if (bus.pc_f !== exp_pc) begin
            errors++; $display("FAIL rhold_pc: got %h want %h", bus.pc_f, exp_pc);
        end
    endtask

    task automatic test_wrap();
        idle_inputs();
        bus.jr_en  = 1'b1;
        bus.rs_val = 32'hFFFF_FFFC;
        exp_q.push_back(32'hFFFF_FFFC);
        tick();
        idle_inputs();
        exp_pc = exp_q.pop_front();
        checks++;
        if (bus.pc_f !== exp_pc) begin
            errors++; $display("FAIL wrap_setup: got %h want %h", bus.pc_f, exp_pc);
        end
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'h0000_0004);
        for (int i = 0; i < 2; i++) begin
            tick();
            exp_pc = exp_q.pop_front();
            checks++;
            if (bus.pc_f !== exp_pc || bus.redirect !== 1'b0) begin
                errors++; $display("FAIL wrap_pc[%0d]: got pc=%h r=%b want pc=%h r=0",
                                   i, bus.pc_f, bus.redirect, exp_pc);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] tgt;
        logic [31:0] pd;
        logic [15:0] im;
        logic [25:0] ix;
        for (int i = 0; i < 9; i++) begin
            idle_inputs();
            pd = $urandom & 32'hFFFF_FFFC;
            im = 16'($urandom);
            ix = 26'($urandom);
            bus.pc_d  = pd;
            bus.imm16 = im;
            bus.idx26 = ix;
            case (i % 3)
                0: begin
                    tgt = $urandom & 32'hFFFF_FFFC;
                    bus.jr_en  = 1'b1;
                    bus.rs_val = tgt;
                end
                1: begin
                    bus.j_en = 1'b1;
                    tgt = pd + 32'd4;
                    tgt = {tgt[31:28], ix, 2'b00};
                end
                default: begin
                    bus.br_en    = 1'b1;
                    bus.br_taken = 1'b1;
                    tgt = pd + 32'd4 + {{14{im[15]}}, im, 2'b00};
                end
            endcase
            #1;
            checks++;
            if (bus.redirect !== 1'b1 || bus.misalign_err !== 1'b0) begin
                errors++; $display("FAIL b2b_pulse[%0d]: got r=%b m=%b want r=1 m=0",
                                   i, bus.redirect, bus.misalign_err);
            end
            exp_q.push_back(tgt);
            tick();
            exp_pc = exp_q.pop_front();
            checks++;
            if (bus.pc_f !== exp_pc) begin
                errors++; $display("FAIL b2b_pc[%0d]: got %h want %h", i, bus.pc_f, exp_pc);
            end
        end
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_stalled_jump();
        test_likely_nt();
        test_jr_misalign();
        test_priority_j_over_br();
        test_reset_in_hold();
        test_wrap();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
